// File: rtl/pwm_multi_if.sv
// Control/status bundle between the motor-control logic and the multi-channel PWM.
// The controller owns duty, polarity and enable; the PWM returns the pin levels and period events.
interface pwm_multi_if #(
  parameter int nbits = 10,
  parameter int nchan = 4
);
  logic                   en;
  logic [nchan*nbits-1:0] duty;
  logic                   load;
  logic [nchan-1:0]       inv;
  logic [nchan-1:0]       out;
  logic                   period_start;
  logic                   load_ack;

  modport master (output en, duty, load, inv, input out, period_start, load_ack);
  modport slave  (input en, duty, load, inv, output out, period_start, load_ack);
endinterface

// File: rtl/pwm_multi.sv
// Multi-channel PWM generator: one shared prescaler and period counter (edge or center aligned).
// Each channel has a double-buffered duty word committed only at a period boundary.
module pwm_multi #(
  parameter int clk_freq = 48000000,
  parameter int freq     = 1000,
  parameter int nbits    = 10,
  parameter int nchan    = 4,
  parameter bit center   = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  pwm_multi_if.slave bus
);
  localparam int max_pwm = (1 << nbits) - 1;
  localparam int max_div = center ? (clk_freq / (freq * 2 * max_pwm)) - 1
                                  : (clk_freq / (freq * (1 << nbits))) - 1;
  localparam int dw = (max_div > 0) ? $clog2(max_div + 1) : 1;
  localparam logic [dw-1:0]    div_last = dw'(max_div);
  localparam logic [nbits-1:0] cnt_top  = '1;

  if (max_div < 0) begin : g_bad_div
    $fatal(1, "pwm_multi: clk_freq too low for freq/nbits, max_div=%0d", max_div);
  end

  logic [dw-1:0]    presc_r;
  logic [nbits-1:0] cnt_r;
  logic [nbits-1:0] cnt_nxt_s;
  logic             dir_r;
  logic             dir_nxt_s;
  logic             pending_r;
  logic [nbits-1:0] active_r [nchan];
  logic [nbits-1:0] shadow_r [nchan];
  logic [nchan-1:0] raw_s;
  logic [nchan-1:0] out_r;
  logic             period_start_r;
  logic             load_ack_r;
  logic             tick_s;
  logic             boundary_s;
  logic             commit_s;

  // next count and direction; dir_r high means counting down (center mode only)
  always_comb begin
    cnt_nxt_s = cnt_r + 1'b1;
    dir_nxt_s = dir_r;
    if (center) begin
      if (dir_r) begin
        cnt_nxt_s = cnt_r - 1'b1;
        if (cnt_nxt_s == '0) begin
          dir_nxt_s = 1'b0;
        end else begin
          dir_nxt_s = 1'b1;
        end
      end else begin
        if (cnt_nxt_s == cnt_top) begin
          dir_nxt_s = 1'b1;
        end else begin
          dir_nxt_s = 1'b0;
        end
      end
    end else begin
      dir_nxt_s = 1'b0;
    end
  end

  assign tick_s     = bus.en && (presc_r == div_last);
  assign boundary_s = tick_s && (cnt_nxt_s == '0) && (cnt_r != '0);
  // a disabled PWM has no period to protect, so a pending shadow commits right away
  assign commit_s   = pending_r && (boundary_s || !bus.en);

  // per-channel compare; a full-scale duty word means 100 % high
  always_comb begin
    raw_s = '0;
    for (int i = 0; i < nchan; i++) begin
      raw_s[i] = (cnt_r < active_r[i]) || (active_r[i] == cnt_top);
    end
  end

  // timebase, duty double-buffering and registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      presc_r        <= '0;
      cnt_r          <= '0;
      dir_r          <= 1'b0;
      pending_r      <= 1'b0;
      out_r          <= '0;
      period_start_r <= 1'b0;
      load_ack_r     <= 1'b0;
      for (int i = 0; i < nchan; i++) begin
        active_r[i] <= '0;
        shadow_r[i] <= '0;
      end
    end else begin
      period_start_r <= boundary_s;
      load_ack_r     <= commit_s;
      if (!bus.en) begin
        presc_r <= '0;
        cnt_r   <= '0;
        dir_r   <= 1'b0;
        out_r   <= bus.inv;
      end else begin
        out_r <= raw_s ^ bus.inv;
        if (tick_s) begin
          presc_r <= '0;
          cnt_r   <= cnt_nxt_s;
          dir_r   <= dir_nxt_s;
        end else begin
          presc_r <= presc_r + 1'b1;
        end
      end
      for (int i = 0; i < nchan; i++) begin
        if (commit_s) begin
          active_r[i] <= shadow_r[i];
        end
        if (bus.load) begin
          shadow_r[i] <= bus.duty[i*nbits +: nbits];
        end
      end
      pending_r <= bus.load || (pending_r && !commit_s);
    end
  end

  assign bus.out          = out_r;
  assign bus.period_start = period_start_r;
  assign bus.load_ack     = load_ack_r;
endmodule

// File: tb/tb_pwm_multi.sv
// Bench for pwm_multi: three instances (edge, center, prescaled edge) share one stimulus stream;
// a phase-based reference model queues expected outputs that are compared after each clock.
module tb_pwm_multi;
  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       load;
  logic [3:0] duty0;
  logic [3:0] duty1;
  logic [1:0] inv;
  int         checks = 0;
  int         errors = 0;

  pwm_multi_if #(.nbits(4), .nchan(2)) ifa ();
  pwm_multi_if #(.nbits(4), .nchan(1)) ifb ();
  pwm_multi_if #(.nbits(4), .nchan(1)) ifc ();

  assign ifa.en = en;  assign ifa.load = load;  assign ifa.duty = {duty1, duty0};  assign ifa.inv = inv;
  assign ifb.en = en;  assign ifb.load = load;  assign ifb.duty = duty0;  assign ifb.inv = inv[0];
  assign ifc.en = en;  assign ifc.load = load;  assign ifc.duty = duty0;  assign ifc.inv = inv[0];

  pwm_multi #(.clk_freq(16000), .freq(1000), .nbits(4), .nchan(2), .center(1'b0))
    dut_a (.clk(clk), .rst(rst), .bus(ifa));
  pwm_multi #(.clk_freq(30000), .freq(1000), .nbits(4), .nchan(1), .center(1'b1))
    dut_b (.clk(clk), .rst(rst), .bus(ifb));
  pwm_multi #(.clk_freq(48000), .freq(1000), .nbits(4), .nchan(1), .center(1'b0))
    dut_c (.clk(clk), .rst(rst), .bus(ifc));

  always #5 clk = ~clk;

  // reference model state, index 0 = edge, 1 = center, 2 = prescaled edge
  int md[3]   = '{0, 0, 2};
  int plen[3] = '{16, 30, 16};
  int nch[3]  = '{2, 1, 1};
  int phase[3] = '{default: 0};
  int pre[3]   = '{default: 0};
  int pend[3]  = '{default: 0};
  int act[3][2];
  int shd[3][2];
  logic [9:0] sb[$];

  function automatic int cnt_of(int k, int ph);
    if (k == 1) return (ph <= 15) ? ph : 30 - ph;
    else return ph;
  endfunction

  // packing: {ack c,b,a, period_start c,b,a, out c, out b, out a[1:0]}
  function automatic logic [9:0] obs();
    return {ifc.load_ack, ifb.load_ack, ifa.load_ack, ifc.period_start, ifb.period_start,
            ifa.period_start, ifc.out, ifb.out, ifa.out};
  endfunction

  task automatic step();
    logic [9:0] e;
    e = '0;
    for (int k = 0; k < 3; k++) begin
      int c, nph;
      bit tk, bnd, cm, o;
      c = cnt_of(k, phase[k]);
      if (!rst) begin
        phase[k] = 0; pre[k] = 0; pend[k] = 0;
        for (int ch = 0; ch < 2; ch++) begin act[k][ch] = 0; shd[k][ch] = 0; end
      end else begin
        tk  = en && (pre[k] == md[k]);
        nph = tk ? (phase[k] + 1) % plen[k] : phase[k];
        bnd = tk && (nph == 0);
        cm  = (pend[k] != 0) && (bnd || !en);
        for (int ch = 0; ch < nch[k]; ch++) begin
          o = en && ((c < act[k][ch]) || (act[k][ch] == 15));
          e[(k == 0) ? ch : k + 1] = o ^ inv[ch];
        end
        e[4+k] = bnd;
        e[7+k] = cm;
        if (!en) begin phase[k] = 0; pre[k] = 0; end
        else begin pre[k] = tk ? 0 : pre[k] + 1; phase[k] = nph; end
        if (cm) begin act[k][0] = shd[k][0]; act[k][1] = shd[k][1]; end
        if (load) begin shd[k][0] = int'(duty0); shd[k][1] = int'(duty1); end
        pend[k] = (load || (pend[k] != 0 && !cm)) ? 1 : 0;
      end
    end
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [9:0] e, o;
    rst = 1'b0; en = 1'b0; load = 1'b0; duty0 = 4'd0; duty1 = 4'd0; inv = 2'b00;
    repeat (2) begin
      step(); e = sb.pop_front(); o = obs(); checks++;
      if (o !== e) begin errors++; $display("FAIL reset_sb t=%0t got %b want %b", $time, o, e); end
    end
    o = obs(); checks++;
    if (o !== 10'b0) begin errors++; $display("FAIL reset_zero got %b want %b", o, 10'b0); end
    rst = 1'b1;
  endtask

  task automatic test_edge();
    logic [9:0] e, o;
    int hi0, hi1, hic, psn;
    duty0 = 4'd4; duty1 = 4'd0; load = 1'b1;
    for (int i = 0; i < 66; i++) begin
      if (i == 1) load = 1'b0;
      if (i == 2) en = 1'b1;
      step(); e = sb.pop_front(); o = obs(); checks++;
      if (o !== e) begin errors++; $display("FAIL edge_sb t=%0t got %b want %b", $time, o, e); end
      if (i == 1) begin
        checks++;
        if (ifa.load_ack !== 1'b1) begin errors++; $display("FAIL edge_ack_disabled got %b want 1", ifa.load_ack); end
      end
    end
    hi0 = 0; hi1 = 0; hic = 0; psn = 0;
    repeat (48) begin
      step(); e = sb.pop_front(); o = obs(); checks++;
      if (o !== e) begin errors++; $display("FAIL edge_win_sb t=%0t got %b want %b", $time, o, e); end
      hi0 += int'(ifa.out[0]); hi1 += int'(ifa.out[1]); hic += int'(ifc.out[0]); psn += int'(ifa.period_start);
    end
    checks += 4;
    if (hi0 != 12) begin errors++; $display("FAIL edge_ch0_high got %0d want 12", hi0); end
    if (hi1 != 0)  begin errors++; $display("FAIL edge_ch1_high got %0d want 0", hi1); end
    if (psn != 3)  begin errors++; $display("FAIL edge_period_start got %0d want 3", psn); end
    if (hic != 12) begin errors++; $display("FAIL presc_high got %0d want 12", hic); end
  endtask

  task automatic test_sat_inv();
    logic [9:0] e, o;
    int bad;
    for (int pass = 0; pass < 2; pass++) begin
      duty0 = (pass == 0) ? 4'd15 : 4'd0; duty1 = duty0;
      inv = (pass == 0) ? 2'b10 : 2'b11; load = 1'b1; bad = 0;
      for (int i = 0; i < 57; i++) begin
        step(); load = 1'b0; e = sb.pop_front(); o = obs(); checks++;
        if (o !== e) begin errors++; $display("FAIL sat_inv_sb t=%0t got %b want %b", $time, o, e); end
        if (i >= 41 && ifa.out !== ((pass == 0) ? 2'b01 : 2'b11)) bad++;
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL sat_inv_level pass %0d got %0d bad cycles want 0", pass, bad); end
    end
  endtask

  task automatic test_double_buffer();
    logic [9:0] e, o;
    int n, hi, acks;
    duty0 = 4'd4; inv = 2'b00; load = 1'b1; n = 0;
    while ((n < 40) || (phase[0] != 7 && n < 80)) begin
      step(); load = 1'b0; n++; e = sb.pop_front(); o = obs(); checks++;
      if (o !== e) begin errors++; $display("FAIL dbuf_sb t=%0t got %b want %b", $time, o, e); end
    end
    duty0 = 4'd12; load = 1'b1; n = 0; hi = 0;
    do begin
      step(); load = 1'b0; n++; e = sb.pop_front(); o = obs(); checks++;
      if (o !== e) begin errors++; $display("FAIL dbuf_sb t=%0t got %b want %b", $time, o, e); end
      hi += int'(ifa.out[0]);
    end while (!ifa.period_start && n < 20);
    checks += 3;
    if (n >= 20) begin errors++; $display("FAIL dbuf_timeout got %0d cycles want <20", n); end
    if (hi != 0) begin errors++; $display("FAIL dbuf_old_tail got %0d want 0", hi); end
    if (ifa.load_ack !== 1'b1) begin errors++; $display("FAIL dbuf_ack_at_start got %b want 1", ifa.load_ack); end
    hi = 0; acks = 0;
    repeat (16) begin
      step(); e = sb.pop_front(); o = obs(); checks++;
      if (o !== e) begin errors++; $display("FAIL dbuf_sb t=%0t got %b want %b", $time, o, e); end
      hi += int'(ifa.out[0]); acks += int'(ifa.load_ack);
    end
    checks += 2;
    if (hi != 12) begin errors++; $display("FAIL dbuf_new_high got %0d want 12", hi); end
    if (acks != 0) begin errors++; $display("FAIL dbuf_extra_ack got %0d want 0", acks); end
  endtask

  task automatic test_load_boundary();
    logic [9:0] e, o;
    int n, hi, acks;
    duty0 = 4'd8; load = 1'b1; n = 0;
    do begin
      step(); load = 1'b0; n++; e = sb.pop_front(); o = obs(); checks++;
      if (o !== e) begin errors++; $display("FAIL lb_sb t=%0t got %b want %b", $time, o, e); end
    end while (phase[0] != 15 && n < 20);
    duty0 = 4'd2; load = 1'b1;
    step(); load = 1'b0; e = sb.pop_front(); o = obs(); checks += 2;
    if (o !== e) begin errors++; $display("FAIL lb_sb t=%0t got %b want %b", $time, o, e); end
    if ({ifa.period_start, ifa.load_ack} !== 2'b11) begin
      errors++; $display("FAIL lb_first_ack got %b want 11", {ifa.period_start, ifa.load_ack});
    end
    for (int w = 0; w < 2; w++) begin
      hi = 0; acks = 0;
      repeat (16) begin
        step(); e = sb.pop_front(); o = obs(); checks++;
        if (o !== e) begin errors++; $display("FAIL lb_sb t=%0t got %b want %b", $time, o, e); end
        hi += int'(ifa.out[0]); acks += int'(ifa.load_ack);
      end
      checks += 2;
      if (hi != ((w == 0) ? 8 : 2)) begin errors++; $display("FAIL lb_high period %0d got %0d want %0d", w, hi, (w == 0) ? 8 : 2); end
      if (acks != ((w == 0) ? 1 : 0)) begin errors++; $display("FAIL lb_acks period %0d got %0d want %0d", w, acks, (w == 0) ? 1 : 0); end
    end
  endtask

  task automatic test_center();
    logic [9:0] e, o;
    int n, hi, psn, want, asym;
    bit pat[30];
    duty0 = 4'd5; duty1 = 4'd5; load = 1'b1; n = 0;
    do begin
      step(); load = 1'b0; n++; e = sb.pop_front(); o = obs(); checks++;
      if (o !== e) begin errors++; $display("FAIL center_sb t=%0t got %b want %b", $time, o, e); end
    end while ((n < 70 || !ifb.period_start) && n < 120);
    checks++;
    if (n >= 120) begin errors++; $display("FAIL center_timeout got %0d cycles want <120", n); end
    hi = 0; psn = 0; want = 0; asym = 0;
    for (int p = 0; p < 30; p++) begin
      step(); e = sb.pop_front(); o = obs(); checks++;
      if (o !== e) begin errors++; $display("FAIL center_sb t=%0t got %b want %b", $time, o, e); end
      pat[p] = ifb.out[0]; hi += int'(ifb.out[0]); psn += int'(ifb.period_start);
      if (cnt_of(1, p) < 5) want++;
    end
    for (int p = 0; p < 30; p++) if (pat[p] != pat[(30 - p) % 30]) asym++;
    checks += 3;
    if (hi != want) begin errors++; $display("FAIL center_high got %0d want %0d", hi, want); end
    if (psn != 1) begin errors++; $display("FAIL center_period_start got %0d want 1", psn); end
    if (asym != 0) begin errors++; $display("FAIL center_symmetry got %0d want 0", asym); end
  endtask

  task automatic test_enable_reset();
    logic [9:0] e, o;
    int n, acks;
    duty0 = 4'd4; duty1 = 4'd9; inv = 2'b01; load = 1'b1;
    repeat (45) begin
      step(); load = 1'b0; e = sb.pop_front(); o = obs(); checks++;
      if (o !== e) begin errors++; $display("FAIL en_sb t=%0t got %b want %b", $time, o, e); end
    end
    en = 1'b0;
    step(); e = sb.pop_front(); o = obs(); checks += 2;
    if (o !== e) begin errors++; $display("FAIL en_sb t=%0t got %b want %b", $time, o, e); end
    if (ifa.out !== 2'b01) begin errors++; $display("FAIL en_low_out got %b want 01", ifa.out); end
    en = 1'b1; n = 0;
    do begin
      step(); n++; e = sb.pop_front(); o = obs(); checks++;
      if (o !== e) begin errors++; $display("FAIL en_sb t=%0t got %b want %b", $time, o, e); end
    end while (!ifa.period_start && n < 40);
    checks++;
    if (n != 16) begin errors++; $display("FAIL en_restart_period got %0d want 16", n); end
    repeat (5) step();
    repeat (5) void'(sb.pop_front());
    duty0 = 4'd9; load = 1'b1;
    step(); load = 1'b0; void'(sb.pop_front());
    rst = 1'b0;
    step(); rst = 1'b1; e = sb.pop_front(); o = obs(); checks += 2;
    if (o !== e) begin errors++; $display("FAIL rst_sb t=%0t got %b want %b", $time, o, e); end
    if (o !== 10'b0) begin errors++; $display("FAIL rst_mid_zero got %b want %b", o, 10'b0); end
    acks = 0;
    repeat (60) begin
      step(); e = sb.pop_front(); o = obs(); checks++;
      if (o !== e) begin errors++; $display("FAIL rst_sb t=%0t got %b want %b", $time, o, e); end
      acks += int'(ifa.load_ack) + int'(ifb.load_ack) + int'(ifc.load_ack);
    end
    checks++;
    if (acks != 0) begin errors++; $display("FAIL rst_discard_ack got %0d want 0", acks); end
  endtask

  initial begin
    test_reset();
    test_edge();
    test_sat_inv();
    test_double_buffer();
    test_load_boundary();
    test_center();
    test_enable_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
